// File: rtl/baby_load_pkg.sv
// Shared types and sizing for the byte-stream RAM loader.
// ST_CHECK exists only when RAM_LOAD_CHECKSUM_EN is defined.
package baby_load_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int WORDS_DEFAULT  = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
`ifdef RAM_LOAD_CHECKSUM_EN
    ST_CHECK   = 3'd3,
`endif
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/ram_load_ctrl_if.sv
// Byte-in / word-write bundle: a valid-ready byte stream plus a single-cycle store write port.
// The slave modport is the loader; the master modport is the byte source and the store.
interface ram_load_ctrl_if #(parameter int ADDR_W = 5);

  logic [baby_load_pkg::BYTE_W-1:0] byte_i;
  logic                             byte_valid_i;
  logic                             byte_ready_o;
  logic [ADDR_W-1:0]                ram_addr_o;
  logic [baby_load_pkg::WORD_W-1:0] ram_data_o;
  logic                             ram_we_o;

  modport slave (
    input  byte_i, byte_valid_i,
    output byte_ready_o, ram_addr_o, ram_data_o, ram_we_o
  );

  modport master (
    output byte_i, byte_valid_i,
    input  byte_ready_o, ram_addr_o, ram_data_o, ram_we_o
  );

endinterface

// File: rtl/ram_load_ctrl_packer.sv
// Packs bytes MSB-first into a 32-bit word; word_o already includes the byte shifted this cycle.
// word_full_o flags the cycle whose accepted byte completes the word; clear_i wins over shift_en_i.
module byte_word_packer
  import baby_load_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clear_i,
  input  logic              shift_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en_i) begin
      word_d = {word_q[WORD_W-BYTE_W-1:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o      = word_d;
  assign word_full_o = shift_en_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/ram_load_ctrl.sv
// Loads WORDS 32-bit words from a byte stream into a store; write strobes one cycle after the 4th byte.
// Ready drops during WRITE/DONE; RAM_LOAD_CHECKSUM_EN adds a trailing XOR checksum byte and error_o.
module ram_load_ctrl
  import baby_load_pkg::*;
#(
  parameter int WORDS  = WORDS_DEFAULT,
  parameter int ADDR_W = 5
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  input  logic           start_i,
  input  logic           abort_i,
  ram_load_ctrl_if.slave bus,
  output logic           busy_o,
  output logic           done_o
`ifdef RAM_LOAD_CHECKSUM_EN
  ,
  output logic           error_o
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, ram_addr_q;
  logic [WORD_W-1:0] ram_data_q;
  logic              rdy_q, we_q, busy_q, done_q;
  logic              xfer, pk_clear, pk_shift, pk_full;
  logic [WORD_W-1:0] pk_word;
`ifdef RAM_LOAD_CHECKSUM_EN
  logic [BYTE_W-1:0] xor_q;
  logic              err_q;
`endif

  assign xfer     = bus.byte_valid_i && rdy_q;
  assign pk_clear = (state_q == ST_IDLE) ? start_i : abort_i;
  assign pk_shift = xfer && (state_q == ST_COLLECT);

  byte_word_packer u_packer (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .clear_i     (pk_clear),
    .shift_en_i  (pk_shift),
    .byte_i      (bus.byte_i),
    .word_o      (pk_word),
    .word_full_o (pk_full)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      rdy_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RAM_LOAD_CHECKSUM_EN
      xor_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      // Abort outranks every other transition, including a completing byte or a pending WRITE exit.
      if (state_q != ST_IDLE && abort_i) begin
        state_q <= ST_IDLE;
        rdy_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q <= ST_COLLECT;
              addr_q  <= '0;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b1;
`ifdef RAM_LOAD_CHECKSUM_EN
              xor_q   <= '0;
              err_q   <= 1'b0;
`endif
            end
          end
          ST_COLLECT: begin
            if (xfer) begin
`ifdef RAM_LOAD_CHECKSUM_EN
              xor_q <= xor_q ^ bus.byte_i;
`endif
              if (pk_full) begin
                state_q    <= ST_WRITE;
                rdy_q      <= 1'b0;
                we_q       <= 1'b1;
                ram_addr_q <= addr_q;
                ram_data_q <= pk_word;
              end
            end
          end
          ST_WRITE: begin
            if (addr_q == LAST_ADDR) begin
`ifdef RAM_LOAD_CHECKSUM_EN
              state_q <= ST_CHECK;
              rdy_q   <= 1'b1;
`else
              state_q <= ST_DONE;
              done_q  <= 1'b1;
`endif
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_COLLECT;
              rdy_q   <= 1'b1;
            end
          end
`ifdef RAM_LOAD_CHECKSUM_EN
          ST_CHECK: begin
            if (xfer) begin
              err_q   <= (xor_q != bus.byte_i);
              state_q <= ST_DONE;
              rdy_q   <= 1'b0;
              done_q  <= 1'b1;
            end
          end
`endif
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.byte_ready_o = rdy_q;
  assign bus.ram_we_o     = we_q;
  assign bus.ram_addr_o   = ram_addr_q;
  assign bus.ram_data_o   = ram_data_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
`ifdef RAM_LOAD_CHECKSUM_EN
  assign error_o          = err_q;
`endif

endmodule
